// File: rtl/registrador_pkg.sv
// Shared types and default sizing for the run-length event recorder.
package registrador_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int LEN_W_DEF = 8;
  localparam int CNT_W_DEF = 8;
  localparam int DEPTH_DEF = 4;

endpackage

// File: rtl/registrador_eventos_fifo_sync.sv
// First-word-fallthrough FIFO: registered storage, wrapping pointers, explicit level.
module fifo_sync #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [LVL_W-1:0] level,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [PTR_W-1:0]            wr_ptr;
  logic [PTR_W-1:0]            rd_ptr;
  logic                        do_push;
  logic                        do_pop;

  assign empty = (level == '0);
  assign full  = (level == LVL_W'(DEPTH));

  // A push into a full FIFO is only legal when the head leaves the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  assign dout = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/registrador_eventos.sv
// Converts each high run of y_in into a buffered run-length record with event count and sticky overflow.
module registrador_eventos
  import registrador_pkg::*;
#(
  parameter int LEN_W = LEN_W_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     y_in,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [LEN_W-1:0]         out_len,
  output logic [CNT_W-1:0]         evt_count,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     overflow
);

  localparam logic [LEN_W-1:0] LEN_MAX = {LEN_W{1'b1}};

  state_t           state;
  logic [LEN_W-1:0] run_len;
  logic             run_done;
  logic             pop;
  logic             full;
  logic             empty;

  assign run_done  = (state == RUN) && !y_in;
  assign pop       = out_ready && !empty;
  assign out_valid = !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      run_len   <= '0;
      evt_count <= '0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (y_in) begin
            state   <= RUN;
            run_len <= LEN_W'(1);
          end
        end
        RUN: begin
          if (y_in) begin
            if (run_len != LEN_MAX) run_len <= run_len + LEN_W'(1);
          end else begin
            state     <= IDLE;
            run_len   <= '0;
            evt_count <= evt_count + CNT_W'(1);
            // Counted even when dropped; only the record is lost.
            if (full && !pop) overflow <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  fifo_sync #(
    .WIDTH (LEN_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (run_done),
    .pop   (pop),
    .din   (run_len),
    .dout  (out_len),
    .level (fifo_level),
    .full  (full),
    .empty (empty)
  );

endmodule

// File: tb/tb_registrador_eventos.sv
// Self-checking bench: two recorders (8-bit and 4-bit length) against a queue-based run model.
module tb_registrador_eventos;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       y_in = 1'b0;
  logic       out_ready = 1'b0;
  logic       va, vb, oa, ob;
  logic [7:0] la, ca, cb;
  logic [3:0] lb;
  logic [2:0] fa, fb;

  always #5 clk = ~clk;

  registrador_eventos #(.LEN_W(8), .CNT_W(8), .DEPTH(DEPTH)) dut_a (
    .clk(clk), .rst(rst), .y_in(y_in), .out_ready(out_ready),
    .out_valid(va), .out_len(la), .evt_count(ca), .fifo_level(fa), .overflow(oa)
  );

  registrador_eventos #(.LEN_W(4), .CNT_W(8), .DEPTH(DEPTH)) dut_b (
    .clk(clk), .rst(rst), .y_in(y_in), .out_ready(out_ready),
    .out_valid(vb), .out_len(lb), .evt_count(cb), .fifo_level(fb), .overflow(ob)
  );

  int errors = 0;
  int checks = 0;

  // Model: unsaturated run lengths in arrival order; saturation applied when presented.
  int q[$];
  int run_m = 0;
  int cnt_m = 0;
  bit ovf_m = 1'b0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin : model
    bit pop;
    if (rst) begin
      q.delete();
      run_m = 0;
      cnt_m = 0;
      ovf_m = 1'b0;
    end else begin
      pop = (q.size() > 0) && out_ready;
      if (pop) void'(q.pop_front());
      if (run_m > 0 && !y_in) begin
        cnt_m = (cnt_m + 1) % 256;
        if (q.size() < DEPTH) q.push_back(run_m);
        else ovf_m = 1'b1;
      end
      run_m = y_in ? run_m + 1 : 0;
    end
  end

  always @(negedge clk) begin : compare
    int head;
    if (chk_en) begin
      head = (q.size() > 0) ? q[0] : 0;
      chk("a_valid", int'(va), int'(q.size() > 0));
      chk("a_len",   int'(la), (head > 255) ? 255 : head);
      chk("a_count", int'(ca), cnt_m);
      chk("a_level", int'(fa), q.size());
      chk("a_ovf",   int'(oa), int'(ovf_m));
      chk("b_valid", int'(vb), int'(q.size() > 0));
      chk("b_len",   int'(lb), (head > 15) ? 15 : head);
      chk("b_count", int'(cb), cnt_m);
      chk("b_level", int'(fb), q.size());
      chk("b_ovf",   int'(ob), int'(ovf_m));
    end
  end

  task automatic cyc(input bit r, input bit y, input bit rd);
    rst = r;
    y_in = y;
    out_ready = rd;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run(input int n, input bit rd_end);
    repeat (n) cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, rd_end);
  endtask

  initial begin
    int exp_drain[4];
    exp_drain = '{2, 3, 4, 7};

    // Reset held two cycles with y_in high
    cyc(1'b1, 1'b1, 1'b0);
    chk_en = 1'b1;
    cyc(1'b1, 1'b1, 1'b0);
    chk("rst_valid", int'(va), 0);
    chk("rst_len",   int'(la), 0);
    chk("rst_count", int'(ca), 0);
    chk("rst_level", int'(fa), 0);
    chk("rst_ovf",   int'(oa), 0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("idle_valid", int'(va), 0);

    // Single run of 3, then pop it
    run(3, 1'b0);
    chk("r3_valid", int'(va), 1);
    chk("r3_len",   int'(la), 3);
    chk("r3_model", q[0], 3);
    chk("r3_count", int'(ca), 1);
    chk("r3_level", int'(fa), 1);
    cyc(1'b0, 1'b0, 1'b1);
    chk("r3_popped", int'(va), 0);
    chk("r3_level0", int'(fa), 0);

    // Fill, push-with-pop on full, then overflow
    cyc(1'b1, 1'b0, 1'b0);
    for (int n = 1; n <= 4; n++) run(n, 1'b0);
    chk("fill_level", int'(fa), 4);
    chk("fill_count", int'(ca), 4);
    run(7, 1'b1);
    chk("pp_level", int'(fa), 4);
    chk("pp_ovf",   int'(oa), 0);
    chk("pp_count", int'(ca), 5);
    run(5, 1'b0);
    chk("ovf_flag",  int'(oa), 1);
    chk("ovf_model", int'(ovf_m), 1);
    chk("ovf_level", int'(fa), 4);
    chk("ovf_count", int'(ca), 6);
    for (int i = 0; i < 4; i++) begin
      chk("drain_len", int'(la), exp_drain[i]);
      cyc(1'b0, 1'b0, 1'b1);
    end
    chk("drain_empty", int'(va), 0);

    // Saturation: 8-bit sees 20, 4-bit sees 15
    run(20, 1'b0);
    chk("sat_a", int'(la), 20);
    chk("sat_b", int'(lb), 15);
    cyc(1'b0, 1'b0, 1'b1);

    // Reset mid-run discards the partial run
    repeat (5) cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("mid_count", int'(ca), 0);
    chk("mid_valid", int'(va), 0);

    // Counter wrap after 256 single-cycle runs
    repeat (256) begin
      cyc(1'b0, 1'b1, 1'b1);
      cyc(1'b0, 1'b0, 1'b1);
    end
    chk("wrap_count", int'(ca), 0);
    chk("wrap_ovf",   int'(oa), 0);

    // Random traffic
    repeat (4000) begin
      cyc($urandom_range(0, 199) == 0, ($urandom % 4) != 0, ($urandom % 3) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
